gb_interrupt_timer: RTL

Memory-mapped responder for the CPU's interrupt and timer registers. It owns IF (0xFF0F), IE (0xFFFF), DIV, TIMA, TMA and TAC (0xFF04–0xFF07). It services CPU bus reads and writes, merges peripheral interrupt requests with the internal timer interrupt, and drives `reg_IF`/`reg_IE` back to the CPU. It honours the CPU's `clear_interrupt_flag` acknowledge and sits beside the CPU on the M-cycle clock domain.

---
 rtl/gb_mmio_pkg.sv | 22 ++
 rtl/gb_timer.sv | 93 +++++++++
 rtl/gb_interrupt_timer.sv | 95 +++++++++
 3 files changed

// File: rtl/gb_mmio_pkg.sv
// Shared constants and types for the interrupt/timer MMIO block.
package gb_mmio_pkg;

    localparam logic [15:0] ADDR_DIV  = 16'hFF04;
    localparam logic [15:0] ADDR_TIMA = 16'hFF05;
    localparam logic [15:0] ADDR_TMA  = 16'hFF06;
    localparam logic [15:0] ADDR_TAC  = 16'hFF07;
    localparam logic [15:0] ADDR_IF   = 16'hFF0F;
    localparam logic [15:0] ADDR_IE   = 16'hFFFF;

    localparam int INT_VBLANK = 0;
    localparam int INT_STAT   = 1;
    localparam int INT_TIMER  = 2;
    localparam int INT_SERIAL = 3;
    localparam int INT_JOYPAD = 4;

    typedef enum logic {
        TIMER_IDLE,
        TIMER_OVF
    } timer_state_t;

endpackage

// File: rtl/gb_timer.sv
// Divider, TIMA/TMA/TAC and the delayed-reload overflow FSM.
module gb_timer
    import gb_mmio_pkg::*;
#(
    parameter int DIV_W = 14
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] wdata,
    input  logic       wr_div,
    input  logic       wr_tima,
    input  logic       wr_tma,
    input  logic       wr_tac,
    output logic [7:0] div_val,
    output logic [7:0] tima_val,
    output logic [7:0] tma_val,
    output logic [2:0] tac_val,
    output logic       timer_irq
);

    logic [DIV_W-1:0] divider;
    logic [7:0]       tima, tima_next, tma;
    logic [2:0]       tac;
    logic             div_bit, sig, sig_q, inc;
    timer_state_t     state, state_next;

    always_comb begin
        case (tac[1:0])
            2'b00:   div_bit = divider[7];
            2'b01:   div_bit = divider[1];
            2'b10:   div_bit = divider[3];
            default: div_bit = divider[5];
        endcase
    end

    // Falling edge of the gated tap; DIV resets and TAC changes can trigger it too.
    assign sig = tac[2] & div_bit;
    assign inc = sig_q & ~sig;

    always_comb begin
        state_next = state;
        tima_next  = tima;
        timer_irq  = 1'b0;
        case (state)
            TIMER_IDLE: begin
                if (wr_tima) begin
                    tima_next = wdata;
                end else if (inc) begin
                    if (tima == 8'hFF) begin
                        tima_next  = 8'h00;
                        state_next = TIMER_OVF;
                    end else begin
                        tima_next = tima + 8'd1;
                    end
                end
            end
            TIMER_OVF: begin
                state_next = TIMER_IDLE;
                if (wr_tima) begin
                    tima_next = wdata;
                end else begin
                    tima_next = wr_tma ? wdata : tma;
                    timer_irq = 1'b1;
                end
            end
            default: state_next = TIMER_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            divider <= '0;
            sig_q   <= 1'b0;
            state   <= TIMER_IDLE;
            tima    <= 8'h00;
            tma     <= 8'h00;
            tac     <= 3'b000;
        end else begin
            divider <= wr_div ? '0 : divider + {{(DIV_W-1){1'b0}}, 1'b1};
            sig_q   <= sig;
            state   <= state_next;
            tima    <= tima_next;
            if (wr_tma) tma <= wdata;
            if (wr_tac) tac <= wdata[2:0];
        end
    end

    assign div_val  = divider[DIV_W-1 -: 8];
    assign tima_val = tima;
    assign tma_val  = tma;
    assign tac_val  = tac;

endmodule

// File: rtl/gb_interrupt_timer.sv
// CPU-facing interrupt/timer registers: decode, IF/IE and acknowledge handling.
module gb_interrupt_timer
    import gb_mmio_pkg::*;
#(
    parameter int DIV_W = 14
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] addr_i,
    input  logic [7:0]  data_i,
    input  logic        wren_i,
    output logic [7:0]  data_o,
    output logic        hit_o,
    input  logic [4:0]  irq_req_i,
    input  logic        clear_interrupt_flag,
    output logic [7:0]  reg_IF,
    output logic [7:0]  reg_IE
);

    logic       sel_div, sel_tima, sel_tma, sel_tac, sel_if, sel_ie;
    logic [7:0] div_val, tima_val, tma_val;
    logic [2:0] tac_val;
    logic       timer_irq;
    logic [4:0] if_q, if_ack, if_next, req;
    logic [7:0] ie_q;
    logic       unused_irq_bit2;

    assign sel_div  = (addr_i == ADDR_DIV);
    assign sel_tima = (addr_i == ADDR_TIMA);
    assign sel_tma  = (addr_i == ADDR_TMA);
    assign sel_tac  = (addr_i == ADDR_TAC);
    assign sel_if   = (addr_i == ADDR_IF);
    assign sel_ie   = (addr_i == ADDR_IE);
    assign hit_o    = sel_div | sel_tima | sel_tma | sel_tac | sel_if | sel_ie;

    gb_timer #(.DIV_W(DIV_W)) u_timer (
        .clk       (clk),
        .reset     (reset),
        .wdata     (data_i),
        .wr_div    (wren_i & sel_div),
        .wr_tima   (wren_i & sel_tima),
        .wr_tma    (wren_i & sel_tma),
        .wr_tac    (wren_i & sel_tac),
        .div_val   (div_val),
        .tima_val  (tima_val),
        .tma_val   (tma_val),
        .tac_val   (tac_val),
        .timer_irq (timer_irq)
    );

    // Request slot 2 belongs to the timer; the peripheral input there is ignored.
    assign unused_irq_bit2 = irq_req_i[INT_TIMER];

    always_comb begin
        req             = 5'b0;
        req[INT_VBLANK] = irq_req_i[INT_VBLANK];
        req[INT_STAT]   = irq_req_i[INT_STAT];
        req[INT_TIMER]  = timer_irq;
        req[INT_SERIAL] = irq_req_i[INT_SERIAL];
        req[INT_JOYPAD] = irq_req_i[INT_JOYPAD];
    end

    // Ack clears the lowest set bit, a write overrides that, new requests always land.
    always_comb begin
        if_ack  = clear_interrupt_flag ? (if_q & (if_q - 5'd1)) : if_q;
        if_next = ((wren_i & sel_if) ? data_i[4:0] : if_ack) | req;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            if_q <= 5'b0;
            ie_q <= 8'h00;
        end else begin
            if_q <= if_next;
            if (wren_i & sel_ie) ie_q <= data_i;
        end
    end

    always_comb begin
        data_o = 8'hFF;
        case (1'b1)
            sel_div:  data_o = div_val;
            sel_tima: data_o = tima_val;
            sel_tma:  data_o = tma_val;
            sel_tac:  data_o = {5'b11111, tac_val};
            sel_if:   data_o = {3'b111, if_q};
            sel_ie:   data_o = ie_q;
            default:  data_o = 8'hFF;
        endcase
    end

    assign reg_IF = {3'b000, if_q};
    assign reg_IE = ie_q;

endmodule
